meter_frame_scheduler: RTL
==========================

# meter_frame_scheduler

Collects the per-channel bar arrays produced by the level-meter position-to-array converters and schedules them onto one shared display-row stream, one channel after another, once per display frame. It caches the latest array from every channel so the converters are never back-pressured. On each frame tick it emits one row per channel in ascending channel order, tagging each row with its channel index and a staleness flag. The block sits between the per-channel converters and the single display writer.

## Interface
- `channels`, default 2: number of meter channels (≥1).
- `width`, default 32: bar array width in bits; must match the converters.
- `clk`  in  1: clock.
- `reset`  in  1: asynchronous, active-high reset.
- `i_valid`  in  `channels`: per-channel array-valid; bit c belongs to channel c.
- `i_ready`  out  `channels`: per-channel ready; all ones after reset (cache always accepts).
- `i_array`  in  `channels*width`: channel c occupies bits [c*width +: width].
- `i_frame_tick`  in  1: one-cycle pulse requesting a frame.
- `o_valid`  out  1: output row valid.
- `o_ready`  in  1: display writer accepts row.
- `o_array`  out  `width`: row data.
- `o_channel`  out  `$clog2(channels)` (min 1): channel index of row.
- `o_first`  out  1: row is channel 0 of a frame.
- `o_stale`  out  1: channel's cache not updated since its previous emission.
- `o_frame_done`  out  1: one-cycle pulse after last row accepted.
- `o_overrun`  out  1: sticky; a frame tick arrived while a frame was in progress.

## Operation
- Per-channel cache: `cache[c]` (`width` bits) and `fresh[c]`. When `i_valid[c]` is high at a clock edge, `cache[c]` ← array c and `fresh[c]` ← 1.
- FSM states IDLE and SEND; `idx` counter 0..channels-1.
- IDLE: if `i_frame_tick`, load output register from `cache[0]`. Set `o_stale` = !`fresh[0]`, clear `fresh[0]`, `o_channel`=0, `o_first`=1, `o_valid`=1, `idx`=0. Go to SEND.
- SEND: hold all outputs stable while `o_valid` && !`o_ready`. On `o_valid` && `o_ready`:
  - if `idx` < channels-1: load channel `idx`+1 the same way, with `o_first`=0. `o_valid` stays 1, so rows go back-to-back.
  - else: `o_valid`←0, `o_frame_done`←1 for one cycle, go to IDLE.
- A frame tick in SEND is ignored and sets `o_overrun`. Only reset clears `o_overrun`.
- A tick in the same cycle the last row is accepted counts as overrun; no new frame starts.
- Simultaneous capture and load of channel c in one edge: the output row takes the pre-update cache value. `fresh[c]` ends at 1, because capture wins over the clear.
- The first frame after reset reports `o_stale`=1 and array 0 for any channel that was never captured.
- channels=1: every row has `o_first`=1 and the frame ends after one row.

## Timing
- Reset values: `i_ready` all ones; `o_valid`, `o_array`, `o_channel`, `o_first`, `o_stale`, `o_frame_done`, `o_overrun` all 0. Caches and `fresh` are 0. State is IDLE.
- Reset asserted mid-frame: `o_valid` drops immediately (asynchronous). No `o_frame_done` is issued, and the pending frame is discarded.
- Tick sampled at edge t → first row visible with `o_valid`=1 after edge t (1-cycle latency).
- With `o_ready` held high, one row is accepted per cycle. The final accept is at edge t+channels, and `o_frame_done` is high in the cycle after it.
- A capture at edge t is visible to any row loaded at edge t+1 or later.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset, then tick with no captures (channels=2) → rows (ch0, array 0, stale 1, first 1) then (ch1, array 0, stale 1, first 0); `o_frame_done` pulses once.
- Capture ch0=0x0000_00FF and ch1=0x0000_0FFF, then tick with `o_ready`=1 → rows 0xFF (stale 0), then 0xFFF (stale 0) on consecutive cycles. A second tick with no new captures → same arrays, both stale 1.
- Tick with `o_ready` low for 5 cycles → `o_valid`, `o_array` and `o_channel` stay constant for the whole stall; the row is accepted on the first cycle `o_ready` is high.
- Tick during SEND → ignored, `o_overrun` goes to 1 and stays; the in-progress frame completes unchanged.
- Capture ch1=0xAAAA in the same edge that ch1 is loaded (old cache 0x5555) → row shows 0x5555; the next frame shows 0xAAAA with stale 0.
- Assert reset while row 1 is pending → all outputs are 0 immediately; the next tick starts at ch0 with `o_first`=1.

Source files
------------

// File: rtl/meter_frame_scheduler.sv
// Caches the latest bar array from each meter channel and, on every frame tick,
// streams one tagged row per channel in ascending order to the display writer.
module meter_frame_scheduler #(
  parameter int unsigned channels = 2,
  parameter int unsigned width    = 32,
  localparam int unsigned ChW     = (channels > 1) ? $clog2(channels) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [channels-1:0]       i_valid,
  output logic [channels-1:0]       i_ready,
  input  logic [channels*width-1:0] i_array,
  input  logic                      i_frame_tick,
  output logic                      o_valid,
  input  logic                      o_ready,
  output logic [width-1:0]          o_array,
  output logic [ChW-1:0]            o_channel,
  output logic                      o_first,
  output logic                      o_stale,
  output logic                      o_frame_done,
  output logic                      o_overrun
);

  localparam logic [ChW-1:0] LastIdx = ChW'(channels - 1);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e                 state_q, state_d;
  logic [ChW-1:0]         idx_q, idx_d;
  logic [width-1:0]       cache_q [channels];
  logic [width-1:0]       cache_d [channels];
  logic [channels-1:0]    fresh_q, fresh_d;
  logic                   valid_q, valid_d;
  logic [width-1:0]       array_q, array_d;
  logic                   first_q, first_d;
  logic                   stale_q, stale_d;
  logic                   done_q, done_d;
  logic                   overrun_q, overrun_d;
  logic                   load_en;
  logic [ChW-1:0]         load_ch;

  // The cache never refuses an array.
  assign i_ready      = '1;
  assign o_valid      = valid_q;
  assign o_array      = array_q;
  assign o_channel    = idx_q;
  assign o_first      = first_q;
  assign o_stale      = stale_q;
  assign o_frame_done = done_q;
  assign o_overrun    = overrun_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cache_d   = cache_q;
    fresh_d   = fresh_q;
    valid_d   = valid_q;
    array_d   = array_q;
    first_d   = first_q;
    stale_d   = stale_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;
    load_en   = 1'b0;
    load_ch   = '0;

    unique case (state_q)
      StIdle: begin
        if (i_frame_tick) begin
          load_en = 1'b1;
          state_d = StSend;
        end
      end
      StSend: begin
        if (i_frame_tick) overrun_d = 1'b1;
        if (valid_q && o_ready) begin
          if (idx_q != LastIdx) begin
            load_en = 1'b1;
            load_ch = idx_q + ChW'(1);
          end else begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Row takes the pre-capture cache value.
    if (load_en) begin
      valid_d          = 1'b1;
      idx_d            = load_ch;
      first_d          = (load_ch == '0);
      array_d          = cache_q[load_ch];
      stale_d          = !fresh_q[load_ch];
      fresh_d[load_ch] = 1'b0;
    end

    // Applied after the load so a same-edge capture leaves fresh set.
    for (int c = 0; c < int'(channels); c++) begin
      if (i_valid[c]) begin
        cache_d[c] = i_array[c*width +: width];
        fresh_d[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      fresh_q   <= '0;
      valid_q   <= 1'b0;
      array_q   <= '0;
      first_q   <= 1'b0;
      stale_q   <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int c = 0; c < int'(channels); c++) cache_q[c] <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      fresh_q   <= fresh_d;
      valid_q   <= valid_d;
      array_q   <= array_d;
      first_q   <= first_d;
      stale_q   <= stale_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      cache_q   <= cache_d;
    end
  end

endmodule
